// File: rtl/elastic_buffer.sv
// elastic_buffer: parametrised DEPTH-entry valid/ready elastic buffer.
// in_ready, level and almost_full come straight from registers, so there is no
// combinational path from out_ready or in_valid into in_ready.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_data/in_valid/in_ready  producer side handshake
//   out_data/out_valid/out_ready consumer side handshake
//   level                      stored entry count (0..DEPTH)
//   almost_full                level >= ALMOST_FULL_LVL
//
// Build option
//   ELASTIC_BUFFER_FALLTHROUGH_EN  when defined, an empty buffer presents in_valid/in_data
//                                  directly on out_* and a word taken the same cycle
//                                  bypasses storage. Undefined: latency is one cycle.
module elastic_buffer #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned ALMOST_FULL_LVL = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         almost_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_AF   = LVL_W'(ALMOST_FULL_LVL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             in_ready_q, in_ready_d;
  logic             almost_full_q, almost_full_d;
  logic             out_valid_q, out_valid_d;

  logic push;
  logic pop;
  logic bypass;
  logic store;
  logic fetch;

  // Output view: either stored head entry or, when empty, the producer word itself.
`ifdef ELASTIC_BUFFER_FALLTHROUGH_EN
  logic empty;
  assign empty     = (level_q == '0);
  assign out_valid = empty ? in_valid : out_valid_q;
  assign out_data  = empty ? in_data  : mem[rd_ptr_q];
  assign bypass    = empty & in_valid & out_ready & ~reset;
`else
  assign out_valid = out_valid_q;
  assign out_data  = mem[rd_ptr_q];
  assign bypass    = 1'b0;
`endif

  assign in_ready    = in_ready_q;
  assign level       = level_q;
  assign almost_full = almost_full_q;

  // Handshakes are ignored while reset is high.
  assign push  = in_valid & in_ready_q & ~reset;
  assign pop   = out_valid & out_ready & ~reset;
  // A bypassed word counts as push+pop but never touches storage.
  assign store = push & ~bypass;
  assign fetch = pop & ~bypass;

  // Next-state: pointers wrap explicitly at DEPTH-1, flags derive from the next level.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    in_ready_d    = in_ready_q;
    almost_full_d = almost_full_q;
    out_valid_d   = out_valid_q;

    if (store) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (fetch) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case ({store, fetch})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    in_ready_d    = (level_d != LVL_FULL);
    almost_full_d = (level_d >= LVL_AF);
    out_valid_d   = (level_d != '0);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      in_ready_q    <= 1'b1;
      almost_full_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      in_ready_q    <= in_ready_d;
      almost_full_q <= almost_full_d;
      out_valid_q   <= out_valid_d;
    end
  end

  // Payload storage, deliberately not reset.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_elastic_buffer.sv
// Scoreboard bench for elastic_buffer: a DEPTH=4 instance for directed tests and a
// DEPTH=3 instance for randomised wrap/ordering traffic.
module tb_elastic_buffer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DEPTH=4 instance
  logic        reset4, in_valid4, in_ready4, out_valid4, out_ready4, almost_full4;
  logic [31:0] in_data4, out_data4;
  logic [2:0]  level4;

  // DEPTH=3 instance
  logic        reset3, in_valid3, in_ready3, out_valid3, out_ready3, almost_full3;
  logic [31:0] in_data3, out_data3;
  logic [1:0]  level3;

  elastic_buffer #(.DATA_WIDTH(32), .DEPTH(4), .ALMOST_FULL_LVL(3)) u_dut4 (
    .clk(clk), .reset(reset4),
    .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready4),
    .level(level4), .almost_full(almost_full4)
  );

  elastic_buffer #(.DATA_WIDTH(32), .DEPTH(3), .ALMOST_FULL_LVL(2)) u_dut3 (
    .clk(clk), .reset(reset3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .level(level3), .almost_full(almost_full3)
  );

  logic [31:0] exp4[$];
  logic [31:0] exp3[$];
  logic [31:0] e4, e3, last4;
  int          pops4 = 0;
  int          pops3 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: compare every accepted output word against the scoreboard head.
  always @(negedge clk) begin
    #1;
    if (!reset4 && out_valid4 && out_ready4) begin
      if (exp4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m4_underflow: got 0x%0h with empty scoreboard", out_data4);
      end else begin
        e4 = exp4.pop_front();
        check("m4_order", out_data4, e4);
      end
      last4 = out_data4;
      pops4++;
    end
  end

  always @(negedge clk) begin
    #1;
    if (!reset3 && out_valid3 && out_ready3) begin
      if (exp3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m3_underflow: got 0x%0h with empty scoreboard", out_data3);
      end else begin
        e3 = exp3.pop_front();
        check("m3_order", out_data3, e3);
      end
      pops3++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One-cycle push attempt on dut4: record expectation if accepted.
  task automatic push4(input logic [31:0] d);
    in_valid4 = 1'b1;
    in_data4  = d;
    @(negedge clk);
    check("push4_in_ready", 32'(in_ready4), 32'd1);
    if (in_ready4) exp4.push_back(d);
    cyc();
  endtask

  initial begin
    int p0;
    int sent;
    int n;
    bit accepted;

    reset4 = 1'b1; in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b0;
    reset3 = 1'b1; in_valid3 = 1'b0; in_data3 = '0; out_ready3 = 1'b0;
    repeat (3) cyc();
    reset4 = 1'b0;
    reset3 = 1'b0;
    cyc();

    // 1: idle after reset
    check("t1_in_ready",    32'(in_ready4),    32'd1);
    check("t1_out_valid",   32'(out_valid4),   32'd0);
    check("t1_level",       32'(level4),       32'd0);
    check("t1_almost_full", 32'(almost_full4), 32'd0);
    check("t1_level3",      32'(level3),       32'd0);

    // 2: fill to full with consumer stalled
    out_ready4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push4(32'hA0 + 32'(i));
      in_valid4 = 1'b1;
      check("t2_level",       32'(level4),       32'(i + 1));
      check("t2_almost_full", 32'(almost_full4), (i + 1 >= 3) ? 32'd1 : 32'd0);
    end
    check("t2_in_ready_full", 32'(in_ready4), 32'd0);
    in_data4 = 32'hA4;
    repeat (2) begin
      @(negedge clk);
      check("t2_held_in_ready", 32'(in_ready4), 32'd0);
      check("t2_head",          out_data4,      32'hA0);
      if (in_ready4) exp4.push_back(in_data4);
      cyc();
    end
    check("t2_level_held", 32'(level4), 32'd4);

    // 3: pop from full, no same-cycle refill, then refill next cycle
    out_ready4 = 1'b1;
    @(negedge clk);
    check("t3_in_ready_pop", 32'(in_ready4), 32'd0);
    cyc();
    out_ready4 = 1'b0;
    check("t3_level_after_pop", 32'(level4),   32'd3);
    check("t3_in_ready_rise",   32'(in_ready4), 32'd1);
    @(negedge clk);
    if (in_ready4) exp4.push_back(in_data4);
    cyc();
    in_valid4 = 1'b0;
    check("t3_level_refill", 32'(level4),       32'd4);
    check("t3_almost_full",  32'(almost_full4), 32'd1);
    out_ready4 = 1'b1;
    repeat (4) cyc();
    check("t3_drained_level", 32'(level4),      32'd0);
    check("t3_scoreboard",    32'(exp4.size()), 32'd0);
    check("t3_last_out",      last4,            32'hA4);

    // 4: streaming with both sides always ready
    p0 = pops4;
    out_ready4 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid4 = 1'b1;
      in_data4  = 32'(i);
      @(negedge clk);
      if (in_ready4) exp4.push_back(in_data4);
      check("t4_in_ready", 32'(in_ready4), 32'd1);
`ifdef ELASTIC_BUFFER_FALLTHROUGH_EN
      check("t4_level",     32'(level4),     32'd0);
      check("t4_out_valid", 32'(out_valid4), 32'd1);
      check("t4_out_data",  out_data4,       32'(i));
`else
      check("t4_level_le1", (level4 <= 3'd1) ? 32'd1 : 32'd0, 32'd1);
      check("t4_out_valid", 32'(out_valid4), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check("t4_out_data", out_data4, 32'(i - 1));
`endif
      cyc();
    end
    in_valid4 = 1'b0;
    repeat (2) cyc();
    check("t4_pops",       32'(pops4 - p0),  32'd100);
    check("t4_level_end",  32'(level4),      32'd0);
    check("t4_scoreboard", 32'(exp4.size()), 32'd0);

    // 6: reset mid-stream discards stored words
    out_ready4 = 1'b0;
    push4(32'h11);
    push4(32'h22);
    in_valid4 = 1'b0;
    check("t6_level2", 32'(level4), 32'd2);
    reset4     = 1'b1;
    in_valid4  = 1'b1;
    in_data4   = 32'h33;
    out_ready4 = 1'b1;
    cyc();
    exp4.delete();
    reset4    = 1'b0;
    in_valid4 = 1'b0;
    check("t6_level0",      32'(level4),       32'd0);
    check("t6_out_valid",   32'(out_valid4),   32'd0);
    check("t6_in_ready",    32'(in_ready4),    32'd1);
    check("t6_almost_full", 32'(almost_full4), 32'd0);
    p0 = pops4;
    push4(32'h55);
    in_valid4 = 1'b0;
    repeat (2) cyc();
    check("t6_pop_count", 32'(pops4 - p0), 32'd1);
    check("t6_first_out", last4,           32'h55);

    // 5: DEPTH=3 random valid/ready, 1000 words
    sent = 0;
    n    = 0;
    while ((sent < 1000 || pops3 < 1000) && n < 20000) begin
      if (!in_valid3 && sent < 1000 && $urandom_range(0, 3) != 0) begin
        in_valid3 = 1'b1;
        in_data3  = 32'hC000_0000 + 32'(sent);
      end
      out_ready3 = ($urandom_range(0, 2) != 0);
      accepted = 1'b0;
      @(negedge clk);
      if (in_valid3 && in_ready3) begin
        exp3.push_back(in_data3);
        accepted = 1'b1;
      end
      cyc();
      if (accepted) begin
        in_valid3 = 1'b0;
        sent++;
      end
      n++;
    end
    out_ready3 = 1'b0;
    check("t5_sent",        32'(sent),         32'd1000);
    check("t5_received",    32'(pops3),        32'd1000);
    check("t5_scoreboard",  32'(exp3.size()),  32'd0);
    check("t5_level",       32'(level3),       32'd0);
    check("t5_in_ready",    32'(in_ready3),    32'd1);
    check("t5_almost_full", 32'(almost_full3), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
